// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, round count,
// default shift schedule, scheduler state encoding and bit-shuffling helpers.
// Table entries use DES numbering (1-based, bit 1 = MSB); the helpers
// translate them onto descending [N-1:0] vectors.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  // Bit r-1 set => round r rotates by one position, otherwise by two.
  localparam logic [15:0] DEFAULT_SHIFT_SCHED = 16'h8103;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  // Permuted choice 1: 64-bit key -> 56-bit C||D, parity bits dropped.
  localparam logic [5:0] PC1_TAB [0:55] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  // Permuted choice 2: 56-bit C||D -> 48-bit round subkey.
  localparam logic [5:0] PC2_TAB [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // DES bit n of a 64-bit key lives at vector index 64-n.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = 56'h0;
    for (int i = 0; i < 56; i++) begin
      cd[55 - i] = key[6'(7'd64 - {1'b0, PC1_TAB[i]})];
    end
    return cd;
  endfunction

  // Rotate one 28-bit half toward the MSB (left) or LSB (right) by 1 or 2.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                        input logic single);
    logic [27:0] r;
    if (left) begin
      r = single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    end else begin
      r = single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    end
    return r;
  endfunction

  // C and D rotate independently; neither half spills into the other.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left,
                                         input logic single);
    return {rot28(cd[55:28], left, single), rot28(cd[27:0], left, single)};
  endfunction

endpackage

// File: rtl/des_key_sched_pc2.sv
// PC2 compression: selects 48 of the 56 C||D bits to form a round subkey.
module des_key_sched_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // Pure wiring permutation; DES bit n of C||D lives at index 56-n.
  always_comb begin
    subkey = 48'h0;
    for (int i = 0; i < 48; i++) begin
      subkey[47 - i] = cd[6'(7'd56 - {1'b0, PC2_TAB[i]})];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key scheduler: streams K1..K16 (encrypt, left rotations)
// or K16..K1 (decrypt, right rotations) one subkey per rk handshake,
// computing each subkey on the fly from a single C||D register.
module des_key_sched
  import des_pkg::*;
#(
  parameter logic [15:0] SHIFT_SCHED = DEFAULT_SHIFT_SCHED,
  parameter bit          CLEAR_IDLE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk_data,
  output logic [3:0]  rk_round,
  output logic        rk_last
);

  localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

  ks_state_e   state_r, state_s;
  logic        dir_r, dir_s;
  logic [55:0] cd_r, cd_s, cd_load_s;
  logic [3:0]  round_r, round_s;
  logic [47:0] subkey_s;
  logic        last_s;
  logic        key_parity_unused;

  // Parity bits (DES bits 8,16,..,64) never reach PC1.
  assign key_parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign cd_load_s = pc1(key_in);

  // Last subkey of a stream depends on the direction captured at load time.
  assign last_s = (state_r == RUN) &&
                  (dir_r ? (round_r == 4'd0) : (round_r == LAST_ROUND));

  // Next-state: load on key accept, advance C||D and round only on rk handshake.
  always_comb begin
    state_s = state_r;
    dir_s   = dir_r;
    cd_s    = cd_r;
    round_s = round_r;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          state_s = RUN;
          dir_s   = decrypt;
          if (decrypt) begin
            // Total rotation over 16 rounds is 28, so C16||D16 equals C0||D0.
            cd_s    = cd_load_s;
            round_s = LAST_ROUND;
          end else begin
            cd_s    = rot_cd(cd_load_s, 1'b1, SHIFT_SCHED[0]);
            round_s = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!rk_ready) begin
          state_s = RUN;
        end else if (last_s) begin
          state_s = IDLE;
        end else if (dir_r) begin
          // Undo the rotation that produced the current round's C||D.
          cd_s    = rot_cd(cd_r, 1'b0, SHIFT_SCHED[round_r]);
          round_s = round_r - 4'd1;
        end else begin
          // Apply the rotation belonging to the next round.
          cd_s    = rot_cd(cd_r, 1'b1, SHIFT_SCHED[round_r + 4'd1]);
          round_s = round_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      dir_r   <= 1'b0;
      cd_r    <= 56'h0;
      round_r <= 4'd0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      cd_r    <= cd_s;
      round_r <= round_s;
    end
  end

  des_key_sched_pc2 u_pc2 (
    .cd     (cd_r),
    .subkey (subkey_s)
  );

  assign key_ready = (state_r == IDLE);
  assign rk_valid  = (state_r == RUN);
  assign rk_round  = round_r;
  assign rk_last   = last_s;
  assign rk_data   = (CLEAR_IDLE && !rk_valid) ? 48'h0 : subkey_s;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed testbench for des_key_sched using the classic 133457799BBCDFF1
// key and its published subkeys K1..K16.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key_in = 64'h0;
  logic        decrypt = 1'b0;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic [47:0] rk_data;
  logic [3:0]  rk_round;
  logic        rk_last;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] T1_KEY      = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY_MASK = 64'h0101010101010101;
  localparam logic [63:0] OTHER_KEY   = 64'h0E329232EA6D0D73;

  typedef struct {
    logic [3:0]  round;
    logic [47:0] key;
  } sk_vec_t;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic        rand_ready;
    logic        inject;
  } run_vec_t;

  sk_vec_t  sk_tab  [16];
  run_vec_t run_tab [6];

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [63:0] k, input logic d);
    int waited;
    waited = 0;
    while (key_ready !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check("load_key_ready", 64'(key_ready), 64'd1);
    key_in    = k;
    decrypt   = d;
    key_valid = 1'b1;
    tick();
    // Changing decrypt and key after the accept must not disturb the stream.
    key_valid = 1'b0;
    decrypt   = ~d;
    key_in    = OTHER_KEY;
  endtask

  task automatic drain(input logic dec, input logic rand_ready, input logic inject,
                       input string tag);
    for (int idx = 0; idx < 16; idx++) begin
      sk_vec_t e;
      int      stalls;
      e      = dec ? sk_tab[15 - idx] : sk_tab[idx];
      stalls = 0;
      if (inject && idx < 15) begin
        key_valid = 1'b1;
        key_in    = OTHER_KEY;
      end else begin
        key_valid = 1'b0;
      end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      while (rk_ready == 1'b0) begin
        tick();
        check({tag, "_stall_valid"}, 64'(rk_valid), 64'd1);
        check({tag, "_stall_data"}, 64'(rk_data), 64'(e.key));
        check({tag, "_stall_round"}, 64'(rk_round), 64'(e.round));
        check({tag, "_stall_last"}, 64'(rk_last), 64'(idx == 15));
        stalls++;
        rk_ready = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      check({tag, "_valid"}, 64'(rk_valid), 64'd1);
      check({tag, "_data"}, 64'(rk_data), 64'(e.key));
      check({tag, "_round"}, 64'(rk_round), 64'(e.round));
      check({tag, "_last"}, 64'(rk_last), 64'(idx == 15));
      check({tag, "_key_ready_busy"}, 64'(key_ready), 64'd0);
      tick();
    end
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    check({tag, "_end_valid"}, 64'(rk_valid), 64'd0);
    check({tag, "_end_key_ready"}, 64'(key_ready), 64'd1);
    check({tag, "_end_last"}, 64'(rk_last), 64'd0);
    check({tag, "_end_data"}, 64'(rk_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sk_tab[0]  = '{4'd0,  48'h1B02EFFC7072};
    sk_tab[1]  = '{4'd1,  48'h79AED9DBC9E5};
    sk_tab[2]  = '{4'd2,  48'h55FC8A42CF99};
    sk_tab[3]  = '{4'd3,  48'h72ADD6DB351D};
    sk_tab[4]  = '{4'd4,  48'h7CEC07EB53A8};
    sk_tab[5]  = '{4'd5,  48'h63A53E507B2F};
    sk_tab[6]  = '{4'd6,  48'hEC84B7F618BC};
    sk_tab[7]  = '{4'd7,  48'hF78A3AC13BFB};
    sk_tab[8]  = '{4'd8,  48'hE0DBEBEDE781};
    sk_tab[9]  = '{4'd9,  48'hB1F347BA464F};
    sk_tab[10] = '{4'd10, 48'h215FD3DED386};
    sk_tab[11] = '{4'd11, 48'h7571F59467E9};
    sk_tab[12] = '{4'd12, 48'h97C5D1FABA41};
    sk_tab[13] = '{4'd13, 48'h5F43B7F2E73A};
    sk_tab[14] = '{4'd14, 48'hBF918D3D3F0A};
    sk_tab[15] = '{4'd15, 48'hCB3D8B0E17F5};

    run_tab[0] = '{T1_KEY,               1'b0, 1'b0, 1'b0};
    run_tab[1] = '{T1_KEY,               1'b1, 1'b0, 1'b0};
    run_tab[2] = '{T1_KEY,               1'b0, 1'b1, 1'b0};
    run_tab[3] = '{T1_KEY,               1'b0, 1'b0, 1'b1};
    run_tab[4] = '{T1_KEY ^ PARITY_MASK, 1'b0, 1'b0, 1'b0};
    run_tab[5] = '{T1_KEY ^ PARITY_MASK, 1'b1, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_rk_valid", 64'(rk_valid), 64'd0);
    check("rst_rk_last", 64'(rk_last), 64'd0);
    check("rst_rk_round", 64'(rk_round), 64'd0);
    check("rst_rk_data", 64'(rk_data), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_key_ready", 64'(key_ready), 64'd1);

    // Encrypt, decrypt, backpressure, ignored reload, parity, back-to-back
    for (int r = 0; r < 6; r++) begin
      load_key(run_tab[r].key, run_tab[r].dec);
      drain(run_tab[r].dec, run_tab[r].rand_ready, run_tab[r].inject,
            $sformatf("run%0d", r));
    end

    // Reset in the middle of a stream, then a fresh load restarts at K1
    load_key(T1_KEY, 1'b0);
    rk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("abort_pre_data", 64'(rk_data), 64'(sk_tab[i].key));
      tick();
    end
    check("abort_k6_round", 64'(rk_round), 64'd5);
    check("abort_k6_data", 64'(rk_data), 64'(sk_tab[5].key));
    rst_n = 1'b0;
    tick();
    check("abort_rk_valid", 64'(rk_valid), 64'd0);
    check("abort_key_ready", 64'(key_ready), 64'd1);
    check("abort_rk_round", 64'(rk_round), 64'd0);
    check("abort_rk_last", 64'(rk_last), 64'd0);
    check("abort_rk_data", 64'(rk_data), 64'd0);
    rst_n    = 1'b1;
    rk_ready = 1'b0;
    tick();
    check("abort_idle_valid", 64'(rk_valid), 64'd0);
    load_key(T1_KEY, 1'b0);
    drain(1'b0, 1'b0, 1'b0, "reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
